// File: rtl/rr_encoder_arbiter.sv
// 16-requester round-robin arbiter with registered one-hot and binary grant outputs.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD revocation counter and the timeout pulse.
module rr_encoder_arbiter #(
    parameter int N_REQ = 16
`ifdef ARB_TIMEOUT_EN
    , parameter int MAX_HOLD = 255
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [3:0]       gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        RELEASE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [3:0]       gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             found;
    logic [3:0]       win;
    logic [3:0]       idx;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    // First active request at or after ptr, wrapping modulo 16.
    always_comb begin
        found = 1'b0;
        win   = 4'd0;
        idx   = 4'd0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr_q + 4'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_d      = hold_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE, RELEASE: begin
                gnt_d       = '0;
                gnt_id_d    = 4'd0;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
                if (enable && found) begin
                    state_d     = BUSY;
                    gnt_d[win]  = 1'b1;
                    gnt_id_d    = win;
                    gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d      = 8'd0;
`endif
                end
            end
            BUSY: begin
                // A normal release wins over a timeout landing on the same cycle.
                if (!req[gnt_id_q]) begin
                    state_d     = RELEASE;
                    gnt_d       = '0;
                    gnt_id_d    = 4'd0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q + 4'd1;
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    hold_d = hold_q + 8'd1;
                    if (hold_q + 8'd1 == MAX_HOLD_C) begin
                        state_d     = RELEASE;
                        gnt_d       = '0;
                        gnt_id_d    = 4'd0;
                        gnt_valid_d = 1'b0;
                        ptr_d       = gnt_id_q + 4'd1;
                        timeout_d   = 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_id_d    = 4'd0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 4'd0;
            gnt_q       <= '0;
            gnt_id_q    <= 4'd0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed bench for rr_encoder_arbiter; build with ARB_TIMEOUT_EN to exercise MAX_HOLD=4 revocation.
module tb_rr_encoder_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] req = 16'h0000;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;

    int total = 0;
    int bad = 0;

`ifdef ARB_TIMEOUT_EN
    rr_encoder_arbiter #(.N_REQ(16), .MAX_HOLD(4)) dut (
`else
    rr_encoder_arbiter #(.N_REQ(16)) dut (
`endif
        .clk(clk), .rst(rst), .enable(enable), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle reset pulse to bring ptr back to 0.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; req = 16'h0000;
        step(); step();
        total++; if (gnt !== 16'h0000) begin bad++; $display("FAIL reset_gnt got=%h want=%h", gnt, 16'h0000); end
        total++; if (gnt_id !== 4'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", gnt_id); end
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", gnt_valid); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
        rst = 1'b0;
        step();
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b want=0", gnt_valid); end
    endtask

    task automatic test_async_reset();
        enable = 1'b1; req = 16'h0020;
        step();
        total++; if (gnt !== 16'h0020) begin bad++; $display("FAIL owner5_gnt got=%h want=%h", gnt, 16'h0020); end
        total++; if (gnt_id !== 4'd5) begin bad++; $display("FAIL owner5_id got=%0d want=5", gnt_id); end
        #2 rst = 1'b1;
        #1;
        total++; if (gnt !== 16'h0000) begin bad++; $display("FAIL async_gnt got=%h want=%h", gnt, 16'h0000); end
        total++; if (gnt_id !== 4'd0) begin bad++; $display("FAIL async_id got=%0d want=0", gnt_id); end
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", gnt_valid); end
        req = 16'h0000;
        step();
        rst = 1'b0;
        step();
        total++; if (gnt_valid !== 1'b0 || gnt !== 16'h0000) begin bad++; $display("FAIL post_reset_idle got=%h want=%h", gnt, 16'h0000); end
    endtask

    task automatic test_single();
        enable = 1'b1; req = 16'h0100;
        step();
        total++; if (gnt !== 16'h0100) begin bad++; $display("FAIL single_gnt got=%h want=%h", gnt, 16'h0100); end
        total++; if (gnt_id !== 4'd8) begin bad++; $display("FAIL single_id got=%0d want=8", gnt_id); end
        total++; if (gnt_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", gnt_valid); end
        step();
        total++; if (gnt !== 16'h0100) begin bad++; $display("FAIL single_hold got=%h want=%h", gnt, 16'h0100); end
        req = 16'h0000;
        step();
        total++; if (gnt !== 16'h0000 || gnt_valid !== 1'b0) begin bad++; $display("FAIL single_release got=%h want=%h", gnt, 16'h0000); end
        step();
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", gnt_valid); end
    endtask

    task automatic test_round_robin();
        logic [15:0] drop [4];
        logic [3:0]  want [4];
        drop = '{16'h8002, 16'h8001, 16'h0003, 16'h8002};
        want = '{4'd0, 4'd1, 4'd15, 4'd0};
        pulse_reset();
        enable = 1'b1; req = 16'h8003;
        step();
        for (int i = 0; i < 4; i++) begin
            total++; if (gnt_id !== want[i] || gnt_valid !== 1'b1) begin bad++; $display("FAIL rr_grant%0d got=%0d want=%0d", i, gnt_id, want[i]); end
            if (i < 3) begin
                req = drop[i];
                step();
                total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL rr_gap%0d got=%b want=0", i, gnt_valid); end
                req = 16'h8003;
                step();
            end
        end
        req = 16'h0000;
        step(); step();
    endtask

    task automatic test_wrap();
        pulse_reset();
        enable = 1'b1; req = 16'h8000;
        step();
        total++; if (gnt_id !== 4'd15) begin bad++; $display("FAIL wrap_owner got=%0d want=15", gnt_id); end
        req = 16'h0001;
        step();
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL wrap_gap got=%b want=0", gnt_valid); end
        step();
        total++; if (gnt !== 16'h0001 || gnt_id !== 4'd0) begin bad++; $display("FAIL wrap_grant got=%h want=%h", gnt, 16'h0001); end
        req = 16'h0000;
        step(); step();
    endtask

    task automatic test_enable();
        enable = 1'b0; req = 16'hFFFF;
        step(); step();
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL en_idle_block got=%b want=0", gnt_valid); end
        pulse_reset();
        enable = 1'b1; req = 16'h0008;
        step();
        total++; if (gnt_id !== 4'd3) begin bad++; $display("FAIL en_owner3 got=%0d want=3", gnt_id); end
        enable = 1'b0; req = 16'hFFFF;
        step(); step();
        total++; if (gnt !== 16'h0008 || gnt_id !== 4'd3) begin bad++; $display("FAIL en_keep got=%h want=%h", gnt, 16'h0008); end
        req = 16'hFFF7;
        step();
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL en_release got=%b want=0", gnt_valid); end
        step(); step();
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL en_no_regrant got=%b want=0", gnt_valid); end
        enable = 1'b1;
        step();
        total++; if (gnt_id !== 4'd4 || gnt_valid !== 1'b1) begin bad++; $display("FAIL en_resume got=%0d want=4", gnt_id); end
        req = 16'h0000;
        step(); step();
    endtask

    task automatic test_timeout();
        pulse_reset();
        enable = 1'b1; req = 16'h0004;
        step();
        total++; if (gnt_id !== 4'd2) begin bad++; $display("FAIL to_owner got=%0d want=2", gnt_id); end
`ifdef ARB_TIMEOUT_EN
        req = 16'h0014;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (gnt_valid !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL to_hold%0d got=%b/%b want=1/0", i, gnt_valid, timeout); end
        end
        step();
        total++; if (gnt_valid !== 1'b0 || timeout !== 1'b1) begin bad++; $display("FAIL to_revoke got=%b/%b want=0/1", gnt_valid, timeout); end
        step();
        total++; if (gnt_id !== 4'd4 || timeout !== 1'b0) begin bad++; $display("FAIL to_next got=%0d/%b want=4/0", gnt_id, timeout); end
`else
        for (int i = 0; i < 20; i++) begin
            step();
            total++; if (gnt_valid !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL no_to_hold%0d got=%b/%b want=1/0", i, gnt_valid, timeout); end
        end
`endif
        req = 16'h0000;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_enable();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_encoder_arbiter.md
Name: rr_encoder_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource, such as the 16-to-4 binary encoder datapath, among 16 requesters.
- Grants exactly one requester at a time and presents the grant both one-hot and as a 4-bit binary index.
- Holds each grant until the owner releases it.
- Sits between requesting channel logic and the shared encoder/result path. Fully sequential and TMR-friendly: all state is in registers and there are no latches.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 so the index is 4 bits.
- MAX_HOLD, 255, maximum BUSY cycles per grant; 8-bit range 1..255; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  1 = new grants allowed; 0 = no new grants (an existing grant is unaffected).
- req  input  16  request vector; requester i holds req[i]=1 for as long as it wants ownership.
- gnt  output  16  registered one-hot grant; all-zero when no owner.
- gnt_id  output  4  registered binary index of the owner; 0 when no owner.
- gnt_valid  output  1  registered; 1 when gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked; always 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async assert, any state, including mid-grant):
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - ptr=0, state=IDLE, hold counter=0.
  - Outputs clear immediately, without waiting for a clock edge.
- State machine, registered states:
  - IDLE: no owner.
  - BUSY: owner holds grant.
  - RELEASE: one-cycle turnaround with gnt=0.
- Arbitration, evaluated in IDLE and RELEASE when enable=1 and req!=0:
  - Winner is the first index k with req[k]=1, searching ptr, ptr+1, ... cyclically mod 16 (15 wraps to 0).
  - Next edge: state=BUSY, gnt=1<<k, gnt_id=k, gnt_valid=1.
- Latency:
  - From IDLE: req sampled at edge t gives gnt at edge t+1.
  - After a release, the next grant appears no earlier than 2 cycles after the owner's req drops.
- BUSY:
  - While req[owner]=1, hold gnt, gnt_id and state unchanged. Other req bits are ignored.
  - When req[owner]=0 is sampled, the next edge sets state=RELEASE, gnt=0, gnt_id=0, gnt_valid=0 and ptr=(owner+1) mod 16.
- RELEASE:
  - Lasts exactly one cycle with no grant.
  - Next state is BUSY if the arbitration above finds a winner, otherwise IDLE.
- enable:
  - enable=0 in IDLE or RELEASE means no grant; go to or stay in IDLE.
  - enable=0 during BUSY does not revoke the grant.
  - ptr does not change while idle.
- Simultaneous requests: only one winner; rotating priority guarantees each persistent requester a grant within 16 grants.
- Owner re-raising req during RELEASE: it has the lowest priority (ptr is already past it). It may win only if no other requester is active.
- Invariants every cycle:
  - gnt is zero or one-hot.
  - gnt_valid == |gnt.
  - gnt_id == encode(gnt).
- Illegal state encodings recover to IDLE with outputs cleared.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to BUSY and increments on each cycle in BUSY.
  - When the count reaches MAX_HOLD while req[owner] is still 1, the next edge forces RELEASE exactly as a normal release (gnt cleared, ptr=owner+1).
  - timeout=1 for that single cycle.
  - A normal release on the same cycle as the limit takes precedence: timeout stays 0.
- Undefined: no counter is built, timeout is tied 0, and grants are held indefinitely.

Test Plan:
- Reset then idle: rst=1 while BUSY with owner 5 -> gnt=0, gnt_id=0, gnt_valid=0 asynchronously; after rst=0 with req=0 the outputs stay 0.
- Single request: enable=1, req=16'h0100 at edge t -> at edge t+1 gnt=16'h0100, gnt_id=8, gnt_valid=1; drop req -> one RELEASE cycle with gnt=0, then IDLE.
- Round-robin: ptr=0, req=16'h8003 held -> grants rotate 0, 1, 15, 0 across successive releases, with exactly one gap cycle between grants.
- Wrap-around: owner 15 releases while req=16'h0001 -> ptr=0, and the next grant is id 0 two cycles after the release.
- Enable gating: enable=0 with req=16'hFFFF in IDLE -> no grant; enable falling while owner 3 is BUSY -> owner 3 keeps the grant until its req drops, then no new grant.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): owner 2 holds req -> after 4 BUSY cycles gnt clears and timeout pulses once; with req=16'h0004|16'h0010 the next grant goes to id 4.
